// File: rtl/fb_write_arbiter.sv
// Round-robin write arbiter for the framebuffer: three pixel producers share
// one registered VGA write port. Out-of-bounds pixels are accepted but dropped
// and counted.
module fb_write_arbiter #(
  parameter int unsigned XMAX      = 240,
  parameter int unsigned YMAX      = 180,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [7:0] y0,
  input  logic [7:0] y1,
  input  logic [7:0] y2,
  input  logic [2:0] colour0,
  input  logic [2:0] colour1,
  input  logic [2:0] colour2,
  input  logic [2:0] last,
  output logic [2:0] gnt,
  output logic [2:0] ack,
  output logic [7:0] vga_x,
  output logic [7:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, stateNext;
  logic [2:0]    gntNext;
  logic [1:0]    rrPtr, rrNext;
  logic [CW-1:0] burstCnt, burstCntNext;
  logic [1:0]    pick, cand;
  logic          pickValid;
  logic [7:0]    selX, selY;
  logic [2:0]    selColour;
  logic          accepted, inBounds, releaseNow;

  // rrPtr doubles as the owner index while a burst is active
  always_comb begin
    selX      = x0;
    selY      = y0;
    selColour = colour0;
    case (rrPtr)
      2'd1: begin selX = x1; selY = y1; selColour = colour1; end
      2'd2: begin selX = x2; selY = y2; selColour = colour2; end
      default: ;
    endcase
  end

  assign ack      = gnt & req;
  assign accepted = |ack;
  assign busy     = |gnt;
  assign inBounds = ({24'd0, selX} < XMAX) && ({24'd0, selY} < YMAX);

  // Search starts just after the previous owner, so a releaser goes last
  always_comb begin
    pick      = rrPtr;
    pickValid = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= 3; i++) begin
      cand = 2'((32'(rrPtr) + i) % 32'd3);
      if (!pickValid && req[cand]) begin
        pick      = cand;
        pickValid = 1'b1;
      end
    end
  end

  // Next-state logic: grant from IDLE, release on last / full burst / req drop
  always_comb begin
    stateNext    = state;
    gntNext      = gnt;
    rrNext       = rrPtr;
    burstCntNext = burstCnt;
    releaseNow   = 1'b0;
    case (state)
      IDLE: begin
        if (pickValid) begin
          stateNext    = BURST;
          gntNext      = 3'b001 << pick;
          rrNext       = pick;
          burstCntNext = '0;
        end
      end
      BURST: begin
        if (accepted) burstCntNext = burstCnt + 1'b1;
        // the granted bit is set, so no ack means that requester dropped req
        releaseNow = !accepted || last[rrPtr] || (burstCnt == LAST_BEAT);
        if (releaseNow) begin
          stateNext = IDLE;
          gntNext   = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        gntNext   = '0;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      rrPtr    <= 2'd2;
      burstCnt <= '0;
    end else begin
      state    <= stateNext;
      gnt      <= gntNext;
      rrPtr    <= rrNext;
      burstCnt <= burstCntNext;
    end
  end

  // Registered framebuffer write port and saturating drop counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      drop_count <= '0;
    end else begin
      vga_plot <= accepted && inBounds;
      if (accepted && inBounds) begin
        vga_x      <= selX;
        vga_y      <= selY;
        vga_colour <= selColour;
      end
      if (accepted && !inBounds && drop_count != '1)
        drop_count <= drop_count + 1'b1;
    end
  end

endmodule
